byte_bus_responder: RTL and testbench
=====================================

Name: byte_bus_responder

Overview:
- Slave/target end of the byte-wide memory bus driven by MEM_Control.
- Serves each mem_a/mem_wr/mem_dout cycle from an on-chip byte RAM or a small memory-mapped IO window.
- The IO window holds a TX FIFO toward the host link, a one-byte RX holding register, status, overflow count and halt.
- Sits between the CPU memory controller and the RAM/host-interface side of the top level.

Parameters:
- ADDR_WIDTH, 17, RAM address bits; RAM is 2^ADDR_WIDTH bytes.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- IO_BASE, 32'h00030000, base of the IO window.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  bus-side enable; low freezes bus-side state.
- mem_a  input  32  byte address from the controller.
- mem_wr  input  1  1 = write this cycle.
- mem_wdata  input  8  write data (controller mem_dout).
- mem_rdata  output  8  read data (controller mem_din).
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts head.
- rx_data  input  8  incoming host byte.
- rx_valid  input  1  incoming byte valid.
- rx_ready  output  1  holding register empty.
- halt_out  output  1  sticky halt request.
- ovf_cnt  output  8  dropped TX bytes, saturating.

Behaviour:
- Reset (rst_n_in low, async) clears everything below except RAM contents, which are not reset.
  - mem_rdata=0, tx_valid=0, FIFO pointers and count=0, rx_avail=0 (so rx_ready=1), halt_out=0, ovf_cnt=0, prev_a=0, prev_wr=0.
  - Reset mid-transfer discards FIFO contents and any held RX byte.
- Decode:
  - IO when mem_a[17:16]==2'b11, i.e. 0x30000-0x3FFFF, matching IO_BASE.
  - Otherwise RAM at index mem_a[ADDR_WIDTH-1:0]; upper bits are ignored, so addresses wrap.
- Read latency is 1 cycle.
  - On each rising edge with rdy_in=1 and mem_wr=0, mem_rdata is loaded from the location at the mem_a present that edge.
  - The controller samples mem_rdata two edges after driving mem_a.
  - mem_rdata holds when mem_wr=1 or rdy_in=0.
- Write: on an edge with rdy_in=1 and mem_wr=1, the location at mem_a takes mem_wdata. Every write cycle takes effect; the controller pulses mem_wr for one cycle per byte.
- Read-begin: a read has side effects only on its first cycle. This holds when rdy_in=1, mem_wr=0, and (mem_a!=prev_a or prev_wr=1). prev_a and prev_wr update on every rdy_in=1 edge. Held addresses therefore do not repeat side effects.
- IO map, using offsets from IO_BASE:
  - +0 write: push mem_wdata into the TX FIFO.
  - +0 read: returns the RX holding byte; on read-begin, clears rx_avail. Returns 0 if empty, with no effect.
  - +4 read: {5'b0, tx_empty, rx_avail, tx_full}.
  - +4 write: sets halt_out=1, which stays set until reset.
  - +8 read: ovf_cnt.
  - Other IO offsets read 0; writes to them are ignored.
- TX FIFO: circular buffer with a count of 0..FIFO_DEPTH; tx_data = head, tx_valid = count!=0.
  - Pop on tx_valid & tx_ready.
  - Push when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs the same cycle (count stays unchanged).
  - Otherwise the byte is dropped and ovf_cnt increments, saturating at 255.
  - Simultaneous push and pop at any count leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- RX holding register:
  - rx_ready = !rx_avail (combinational).
  - Captures rx_data and sets rx_avail on rx_valid & rx_ready.
  - A clear and a capture cannot coincide, because rx_ready is low while the register is full.
- rdy_in=0 freezes RAM writes, IO pushes and halt, read side effects, mem_rdata, prev_a and prev_wr.
  - TX pop and RX capture handshakes continue regardless of rdy_in.

Test Plan:
- Write bytes 0x78,0x56,0x34,0x12 to RAM 0x100..0x103 with single-cycle mem_wr pulses, then read each with address held for 2 cycles -> mem_rdata = 0x78,0x56,0x34,0x12 one cycle after each address; read 0x20100 -> 0x78 (wrap).
- With tx_ready=0, write 18 bytes 0x00..0x11 to 0x30000 -> status bit0=1, ovf_cnt=2; then tx_ready=1 -> tx_data streams 0x00..0x0F, then tx_valid=0.
- FIFO full, tx_ready=1 and a write of 0xAA in the same cycle -> no overflow, count stays 16, 0xAA is the last byte out.
- rx_valid=1 with rx_data=0x5A -> rx_ready falls; read 0x30004 -> 0x06; hold mem_a=0x30000 for 3 cycles -> 0x5A, rx_avail cleared once; next read-begin of 0x30000 -> 0x00.
- Write 0x30004 -> halt_out=1; with rdy_in=0, write 0x30000 -> no push, mem_rdata unchanged.
- Assert rst_n_in mid-stream with 5 bytes queued -> tx_valid, halt_out, ovf_cnt and mem_rdata drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/byte_bus_responder.sv
// Byte-wide bus target: on-chip byte RAM plus an IO window holding a TX FIFO,
// an RX holding register, status, a saturating overflow count and sticky halt.
module byte_bus_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt_out,
    output logic [7:0]  ovf_cnt
);
    localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [7:0] ram_mem  [RAM_BYTES];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [7:0]    mem_rdata_q, mem_rdata_d;
    logic [31:0]   prev_a_q, prev_a_d;
    logic          prev_wr_q, prev_wr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_avail_q, rx_avail_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          halt_q, halt_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;

    logic                  is_io;
    logic [15:0]           io_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  rd_begin, bus_wr, ram_we, push, push_ok, drop, pop;
    logic                  halt_set, rx_cap, rx_clr, tx_empty, tx_full;
    logic [7:0]            rd_val;

    always_comb begin
        is_io    = (mem_a[17:16] == IO_BASE[17:16]);
        io_off   = mem_a[15:0];
        ram_idx  = mem_a[ADDR_WIDTH-1:0];
        rd_begin = rdy_in && !mem_wr && ((mem_a != prev_a_q) || prev_wr_q);
        bus_wr   = rdy_in && mem_wr;
        ram_we   = bus_wr && !is_io;
        push     = bus_wr && is_io && (io_off == 16'h0000);
        halt_set = bus_wr && is_io && (io_off == 16'h0004);
        tx_empty = (cnt_q == '0);
        tx_full  = (cnt_q == FULL_CNT);
        pop      = !tx_empty && tx_ready;
        push_ok  = push && (!tx_full || pop);
        drop     = push && !push_ok;
        rx_cap   = rx_valid && !rx_avail_q;
        rx_clr   = rd_begin && is_io && (io_off == 16'h0000) && rx_avail_q;

        rd_val = '0;
        if (is_io) begin
            case (io_off)
                // RX byte is latched on read-begin so a held read keeps returning it
                16'h0000: rd_val = rd_begin ? (rx_avail_q ? rx_byte_q : 8'h00) : mem_rdata_q;
                16'h0004: rd_val = {5'b0, tx_empty, rx_avail_q, tx_full};
                16'h0008: rd_val = ovf_cnt_q;
                default:  rd_val = '0;
            endcase
        end else begin
            rd_val = ram_mem[ram_idx];
        end
    end

    always_comb begin
        mem_rdata_d = mem_rdata_q;
        prev_a_d    = prev_a_q;
        prev_wr_d   = prev_wr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + CW'(push_ok) - CW'(pop);
        rx_avail_d  = rx_avail_q;
        rx_byte_d   = rx_byte_q;
        halt_d      = halt_q || halt_set;
        ovf_cnt_d   = ovf_cnt_q;

        if (rdy_in) begin
            prev_a_d  = mem_a;
            prev_wr_d = mem_wr;
            if (!mem_wr) mem_rdata_d = rd_val;
        end
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
        if (rx_cap) begin
            rx_avail_d = 1'b1;
            rx_byte_d  = rx_data;
        end else if (rx_clr) begin
            rx_avail_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we)  ram_mem[ram_idx]   <= mem_wdata;
        if (push_ok) fifo_mem[wr_ptr_q] <= mem_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_rdata_q <= '0;
            prev_a_q    <= '0;
            prev_wr_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rx_avail_q  <= 1'b0;
            rx_byte_q   <= '0;
            halt_q      <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            mem_rdata_q <= mem_rdata_d;
            prev_a_q    <= prev_a_d;
            prev_wr_q   <= prev_wr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rx_avail_q  <= rx_avail_d;
            rx_byte_q   <= rx_byte_d;
            halt_q      <= halt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign tx_data   = fifo_mem[rd_ptr_q];
    assign tx_valid  = !tx_empty;
    assign rx_ready  = !rx_avail_q;
    assign halt_out  = halt_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_byte_bus_responder.sv
// Bench for byte_bus_responder: directed scenarios plus random bus traffic,
// checked every cycle against a queue/array reference model.
module tb_byte_bus_responder;
    localparam int unsigned DEPTH = 16;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt_out;
    logic [7:0]  ovf_cnt;

    byte_bus_responder #(
        .ADDR_WIDTH(17),
        .FIFO_DEPTH(DEPTH),
        .IO_BASE   (32'h0003_0000)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .halt_out (halt_out),
        .ovf_cnt  (ovf_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state
    logic [7:0]  ram_m [int unsigned];
    logic [7:0]  txq [$];
    bit          m_rx_avail;
    logic [7:0]  m_rx_byte;
    bit          m_halt;
    int unsigned m_ovf;
    logic [31:0] m_prev_a;
    bit          m_prev_wr;
    logic [7:0]  m_rdata;
    bit          m_rdata_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        m_rx_avail    = 0;
        m_rx_byte     = 8'h00;
        m_halt        = 0;
        m_ovf         = 0;
        m_prev_a      = 32'h0;
        m_prev_wr     = 0;
        m_rdata       = 8'h00;
        m_rdata_known = 1;
    endtask

    // One clock: predict from current inputs, advance, then compare all outputs.
    task automatic step();
        bit          io, pop, push, clr, cap, first, ram_wr, new_known;
        logic [15:0] off;
        int unsigned idx, sz;
        logic [7:0]  val, wd;
        sz        = txq.size();
        io        = (mem_a[17:16] == 2'b11);
        off       = mem_a[15:0];
        idx       = {15'b0, mem_a[16:0]};
        wd        = mem_wdata;
        pop       = (sz != 0) && tx_ready;
        cap       = rx_valid && !m_rx_avail;
        push      = 0;
        clr       = 0;
        ram_wr    = 0;
        val       = m_rdata;
        new_known = m_rdata_known;
        if (rdy_in) begin
            if (mem_wr) begin
                if (!io) ram_wr = 1;
                else if (off == 16'h0000) push = 1;
                else if (off == 16'h0004) m_halt = 1;
            end else begin
                first = (mem_a != m_prev_a) || m_prev_wr;
                new_known = 1;
                if (io) begin
                    if (off == 16'h0000) begin
                        if (first) begin
                            val = m_rx_avail ? m_rx_byte : 8'h00;
                            clr = m_rx_avail;
                        end else begin
                            new_known = m_rdata_known;
                        end
                    end else if (off == 16'h0004) begin
                        val = {5'b0, sz == 0, m_rx_avail, sz == DEPTH};
                    end else if (off == 16'h0008) begin
                        val = 8'(m_ovf);
                    end else begin
                        val = 8'h00;
                    end
                end else if (ram_m.exists(idx)) begin
                    val = ram_m[idx];
                end else begin
                    new_known = 0;
                end
            end
            m_prev_a  = mem_a;
            m_prev_wr = mem_wr;
        end
        @(posedge clk_in);
        #1;
        m_rdata       = val;
        m_rdata_known = new_known;
        if (ram_wr) ram_m[idx] = wd;
        if (pop) void'(txq.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) txq.push_back(wd);
            else if (m_ovf < 255) m_ovf++;
        end
        if (cap) begin
            m_rx_avail = 1;
            m_rx_byte  = rx_data;
        end else if (clr) begin
            m_rx_avail = 0;
        end
        if (m_rdata_known) check_eq("mem_rdata", mem_rdata, m_rdata);
        check_eq("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) check_eq("tx_data", tx_data, txq[0]);
        check_eq("rx_ready", rx_ready, !m_rx_avail);
        check_eq("halt_out", halt_out, m_halt);
        check_eq("ovf_cnt", ovf_cnt, m_ovf);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        mem_a     = a;
        mem_wr    = 1'b1;
        mem_wdata = d;
        step();
        mem_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input int unsigned n);
        mem_a  = a;
        mem_wr = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b [4];
        logic [7:0] e;
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};

        rst_n_in  = 1'b1;
        rdy_in    = 1'b1;
        mem_a     = 32'h0;
        mem_wr    = 1'b0;
        mem_wdata = 8'h00;
        tx_ready  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        #1 rst_n_in = 1'b0;
        #2;
        check_eq("rst_rdata", mem_rdata, 8'h00);
        check_eq("rst_tx_valid", tx_valid, 1'b0);
        check_eq("rst_rx_ready", rx_ready, 1'b1);
        check_eq("rst_halt", halt_out, 1'b0);
        check_eq("rst_ovf", ovf_cnt, 8'h00);
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // RAM write/read and address wrap
        for (int i = 0; i < 4; i++) bus_write(32'h100 + i, exp_b[i]);
        for (int i = 0; i < 4; i++) begin
            bus_read(32'h100 + i, 2);
            check_eq("ram_rd", mem_rdata, exp_b[i]);
        end
        bus_read(32'h20100, 2);
        check_eq("ram_wrap", mem_rdata, 8'h78);

        // FIFO overflow, then stream out
        for (int i = 0; i < 18; i++) bus_write(32'h30000, 8'(i));
        bus_read(32'h30004, 1);
        check_eq("status_full", mem_rdata, 8'h01);
        check_eq("ovf_two", ovf_cnt, 8'd2);
        bus_read(32'h30008, 1);
        check_eq("ovf_rd", mem_rdata, 8'd2);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("stream", tx_data, 8'(i));
            step();
        end
        check_eq("drained", tx_valid, 1'b0);

        // Push into a full FIFO in the same cycle as a pop
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus_write(32'h30000, 8'(8'h80 + i));
        tx_ready = 1'b1;
        bus_write(32'h30000, 8'hAA);
        tx_ready = 1'b0;
        check_eq("full_pop_ovf", ovf_cnt, 8'd2);
        bus_read(32'h30004, 1);
        check_eq("full_pop_status", mem_rdata, 8'h01);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? 8'(8'h81 + i) : 8'hAA;
            check_eq("full_pop_order", tx_data, e);
            step();
        end

        // RX holding register
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        step();
        rx_valid = 1'b0;
        check_eq("rx_full", rx_ready, 1'b0);
        bus_read(32'h30004, 1);
        check_eq("rx_status", mem_rdata, 8'h06);
        mem_a = 32'h30000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rx_hold", mem_rdata, 8'h5A);
        end
        check_eq("rx_cleared", rx_ready, 1'b1);
        bus_read(32'h30008, 1);
        bus_read(32'h30000, 1);
        check_eq("rx_empty_rd", mem_rdata, 8'h00);

        // Halt and rdy_in freeze
        bus_read(32'h101, 1);
        bus_write(32'h30004, 8'h00);
        check_eq("halt_set", halt_out, 1'b1);
        rdy_in = 1'b0;
        bus_write(32'h30000, 8'h33);
        check_eq("frz_push", tx_valid, 1'b0);
        check_eq("frz_rdata", mem_rdata, 8'h56);
        bus_read(32'h100, 1);
        check_eq("frz_read", mem_rdata, 8'h56);
        rdy_in = 1'b1;

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 0) a = mem_a;
            else if (r < 6) a = 32'h200 + $urandom_range(0, 15) + 32'h20000 * $urandom_range(0, 2);
            else if (r == 6) a = 32'h30000;
            else if (r == 7) a = 32'h30004;
            else if (r == 8) a = 32'h30008;
            else a = 32'h3000C;
            mem_a     = a;
            mem_wr    = ($urandom_range(0, 2) == 0);
            mem_wdata = 8'($urandom);
            rdy_in    = ($urandom_range(0, 7) != 0);
            tx_ready  = $urandom_range(0, 1) == 1;
            rx_valid  = ($urandom_range(0, 2) == 0);
            rx_data   = 8'($urandom);
            step();
        end
        mem_wr   = 1'b0;
        rdy_in   = 1'b1;
        rx_valid = 1'b0;

        // Overflow counter saturation
        tx_ready = 1'b0;
        for (int i = 0; i < 275; i++) bus_write(32'h30000, 8'(i));
        check_eq("ovf_sat", ovf_cnt, 8'hFF);

        // Async reset with bytes queued
        tx_ready = 1'b1;
        bus_read(32'h30008, 20);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(32'h30000, 8'(8'hC0 + i));
        bus_read(32'h100, 2);
        check_eq("pre_rst_rdata", mem_rdata, 8'h78);
        rst_n_in = 1'b0;
        #1;
        check_eq("arst_tx_valid", tx_valid, 1'b0);
        check_eq("arst_halt", halt_out, 1'b0);
        check_eq("arst_ovf", ovf_cnt, 8'h00);
        check_eq("arst_rdata", mem_rdata, 8'h00);
        check_eq("arst_rx_ready", rx_ready, 1'b1);
        model_reset();
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        bus_write(32'h30000, 8'h42);
        check_eq("post_rst_push", tx_data, 8'h42);
        bus_read(32'h100, 2);
        check_eq("ram_retained", mem_rdata, 8'h78);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
